// File: rtl/mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 encodings,
// FSM state type, special-case result constants and operand sign helpers.
package mdu_pkg;

    localparam int MDU_XLEN = 32;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [MDU_XLEN-1:0] QUO_ALL_ONES = 32'hFFFF_FFFF;
    localparam logic [MDU_XLEN-1:0] INT_MIN      = 32'h8000_0000;

    // MUL treats both operands as unsigned: its low word does not depend on sign.
    function automatic logic op_signed_a(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_signed_b(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic [MDU_XLEN-1:0] abs_val(input logic [MDU_XLEN-1:0] x,
                                                    input logic              sgn);
        return (sgn && x[MDU_XLEN-1]) ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative 32-step datapath: shift-add multiply or restoring divide over
// unsigned magnitudes. hi/lo hold {product} or {remainder, quotient}.
module mdu_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic            step_i,
    input  logic            is_div_i,
    input  logic [XLEN-1:0] opa_i,
    input  logic [XLEN-1:0] opb_i,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o,
    output logic            last_o
);

    localparam int CW = $clog2(XLEN);

    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;
    logic [XLEN-1:0] opb_q;
    logic            is_div_q;

    logic [XLEN:0]   add_sum;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   trial;
    logic            ge;

    // Remainder stays below the divisor, so the trial subtraction's top bit is a clean borrow.
    always_comb begin
        add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
        shifted = {hi_q, lo_q[XLEN-1]};
        trial   = shifted - {1'b0, opb_q};
        ge      = ~trial[XLEN];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opb_q    <= '0;
            is_div_q <= 1'b0;
        end else if (load_i) begin
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= opa_i;
            opb_q    <= opb_i;
            is_div_q <= is_div_i;
        end else if (step_i) begin
            cnt_q <= cnt_q + 1'b1;
            if (is_div_q) begin
                hi_q <= ge ? trial[XLEN-1:0] : shifted[XLEN-1:0];
                lo_q <= {lo_q[XLEN-2:0], ge};
            end else begin
                hi_q <= add_sum[XLEN:1];
                lo_q <= {add_sum[0], lo_q[XLEN-1:1]};
            end
        end
    end

    assign hi_o   = hi_q;
    assign lo_o   = lo_q;
    assign last_o = step_i && (cnt_q == CW'(XLEN-1));

endmodule

// File: rtl/mdu.sv
// RV32M multiply/divide unit: IDLE/CALC/DONE control, operand latching,
// sign correction, divide special cases and register-file write-back.
module mdu
    import mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [4:0]      rd_adr_i,
    input  logic            kill_i,
    output logic            busy_o,
    output logic            we_o,
    output logic [4:0]      wb_adr_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic [1:0]      dbg_state_o
);

    // Handshake: a request is taken only when start_i is high, kill_i is low and the
    // unit is IDLE (busy_o low); the result appears for exactly one cycle with we_o.

    state_e          state_q, state_d;
    logic [2:0]      op_q;
    logic [XLEN-1:0] a_q;
    logic [4:0]      rd_q;
    logic            a_neg_q, b_neg_q;
    logic            dz_q, ovf_q;

    logic            accept;
    logic            in_dz, in_ovf;
    logic            in_sa, in_sb;
    logic [XLEN-1:0] mag_a, mag_b;
    logic [XLEN-1:0] hi, lo;
    logic            last;
    logic            step;

    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;
    logic [XLEN-1:0]   result;

    always_comb begin
        accept = (state_q == ST_IDLE) && start_i && !kill_i;
        in_dz  = op_i[2] && (b_i == '0);
        in_ovf = op_i[2] && !op_i[0] && (a_i == INT_MIN) && (b_i == QUO_ALL_ONES);
        in_sa  = op_signed_a(op_i);
        in_sb  = op_signed_b(op_i);
        mag_a  = abs_val(a_i, in_sa);
        mag_b  = abs_val(b_i, in_sb);
        step   = (state_q == ST_CALC) && !kill_i;
    end

    mdu_iter #(.XLEN(XLEN)) u_iter (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (accept),
        .step_i   (step),
        .is_div_i (op_i[2]),
        .opa_i    (mag_a),
        .opb_i    (mag_b),
        .hi_o     (hi),
        .lo_o     (lo),
        .last_o   (last)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            rd_q    <= '0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q    <= op_i;
                a_q     <= a_i;
                rd_q    <= rd_adr_i;
                a_neg_q <= in_sa && a_i[XLEN-1];
                b_neg_q <= in_sb && b_i[XLEN-1];
                dz_q    <= in_dz;
                ovf_q   <= in_ovf;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = (in_dz || in_ovf) ? ST_DONE : ST_CALC;
            ST_CALC: begin
                if (kill_i)    state_d = ST_IDLE;
                else if (last) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Magnitudes were used in the datapath; restore the sign of the selected result here.
    always_comb begin
        prod     = {hi, lo};
        prod_fix = (a_neg_q ^ b_neg_q) ? (~prod + 64'd1) : prod;
        quo_fix  = (a_neg_q ^ b_neg_q) ? (~lo + 32'd1) : lo;
        rem_fix  = a_neg_q ? (~hi + 32'd1) : hi;
        result   = '0;
        if (dz_q) begin
            result = op_q[1] ? a_q : QUO_ALL_ONES;
        end else if (ovf_q) begin
            result = op_q[1] ? '0 : INT_MIN;
        end else begin
            case (op_q)
                OP_MUL:                       result = prod_fix[XLEN-1:0];
                OP_MULH, OP_MULHSU, OP_MULHU: result = prod_fix[2*XLEN-1:XLEN];
                OP_DIV, OP_DIVU:              result = quo_fix;
                default:                      result = rem_fix;
            endcase
        end
    end

    always_comb begin
        busy_o      = (state_q != ST_IDLE);
        we_o        = (state_q == ST_DONE) && !kill_i && (rd_q != 5'd0);
        wb_adr_o    = (state_q == ST_DONE) ? rd_q : 5'd0;
        wb_data_o   = (state_q == ST_DONE) ? result : '0;
        dbg_state_o = state_q;
    end

endmodule

// File: tb/tb_mdu.sv
// Directed plus randomised bench for mdu: scoreboard of expected write-backs,
// latency and busy-window checks, kill and reset scenarios.
module tb_mdu;
    import mdu_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic [4:0]  rd_adr_i;
    logic        kill_i;
    logic        busy_o;
    logic        we_o;
    logic [4:0]  wb_adr_o;
    logic [31:0] wb_data_o;
    logic [1:0]  dbg_state_o;

    int n_vec = 0;
    int n_err = 0;
    logic [36:0] exp_q[$];

    always #5 clk_i = ~clk_i;

    mdu #(.XLEN(32)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .op_i        (op_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .rd_adr_i    (rd_adr_i),
        .kill_i      (kill_i),
        .busy_o      (busy_o),
        .we_o        (we_o),
        .wb_adr_o    (wb_adr_o),
        .wb_data_o   (wb_data_o),
        .dbg_state_o (dbg_state_o)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_mdu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa;
        longint sb;
        longint ub;
        longint unsigned ua64;
        longint unsigned ub64;
        logic [63:0] p;
        int q;
        logic ovf;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        ub   = longint'({32'h0, b});
        ua64 = {32'h0, a};
        ub64 = {32'h0, b};
        ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            OP_MUL:    begin p = sa * sb;     return p[31:0];  end
            OP_MULH:   begin p = sa * sb;     return p[63:32]; end
            OP_MULHSU: begin p = sa * ub;     return p[63:32]; end
            OP_MULHU:  begin p = ua64 * ub64; return p[63:32]; end
            OP_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                q = $signed(a) / $signed(b);
                return q;
            end
            OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REM: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                q = $signed(a) % $signed(b);
                return q;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic is_special(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
        return op[2] && ((b == 0) ||
               (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    task automatic do_reset();
        rst_i = 1'b1; start_i = 1'b0; kill_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    // Presents a request for one cycle, then scrambles the inputs to prove they were latched.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        start_i = 1'b1; op_i = op; a_i = a; b_i = b; rd_adr_i = rd;
        @(negedge clk_i);
        start_i = 1'b0;
        op_i = 3'($urandom_range(0, 7)); a_i = $urandom; b_i = $urandom;
        rd_adr_i = 5'($urandom_range(0, 31));
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd);
        int lat;
        int early;
        logic [36:0] e;
        lat   = is_special(op, a, b) ? 1 : 33;
        early = 0;
        if (rd != 0) exp_q.push_back({rd, ref_mdu(op, a, b)});
        issue(op, a, b, rd);
        for (int cyc = 1; cyc < lat; cyc++) begin
            if (we_o !== 1'b0 || busy_o !== 1'b1) early++;
            @(negedge clk_i);
        end
        chk({tag, " busy_window"}, 64'(early), 64'd0);
        chk({tag, " done_busy"}, busy_o, 1'b1);
        chk({tag, " we"}, we_o, rd != 0);
        if (rd != 0) begin
            chk({tag, " sb_depth"}, exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({tag, " wb"}, {wb_adr_o, wb_data_o}, e);
            end
        end else begin
            chk({tag, " wb_adr_rd0"}, wb_adr_o, 5'd0);
        end
        @(negedge clk_i);
        chk({tag, " idle_after"}, {busy_o, we_o, wb_adr_o, wb_data_o}, 39'd0);
    endtask

    initial begin
        int seen;
        logic [2:0]  r_op;
        logic [31:0] r_a, r_b;
        int sel;

        op_i = '0; a_i = '0; b_i = '0; rd_adr_i = '0;
        do_reset();
        chk("reset_outputs", {busy_o, we_o, wb_adr_o, wb_data_o}, 39'd0);
        chk("reset_state", dbg_state_o, 2'd0);

        run_op("mul_7_m3",   OP_MUL,    32'd7,          32'hFFFF_FFFD, 5'd5);
        run_op("mulhu_ones", OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd1);
        run_op("mulh_ones",  OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2);
        run_op("mulhsu_m1",  OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3);
        run_op("div_m20_6",  OP_DIV,    32'hFFFF_FFEC,  32'd6,         5'd4);
        run_op("rem_m20_6",  OP_REM,    32'hFFFF_FFEC,  32'd6,         5'd6);
        run_op("divu_20_6",  OP_DIVU,   32'd20,         32'd6,         5'd7);
        run_op("divu_by0",   OP_DIVU,   32'd5,          32'd0,         5'd8);
        run_op("div_by0",    OP_DIV,    32'hFFFF_FF00,  32'd0,         5'd9);
        run_op("rem_by0",    OP_REM,    32'hFFFF_FF00,  32'd0,         5'd10);
        run_op("remu_by0",   OP_REMU,   32'd77,         32'd0,         5'd11);
        run_op("rem_ovf",    OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd12);
        run_op("div_ovf",    OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd13);
        run_op("mul_big",    OP_MUL,    32'h1234_5678,  32'h9ABC_DEF0, 5'd31);

        // kill during CALC; a start request mid-operation must be ignored
        seen = 0;
        issue(OP_DIV, 32'hFFFF_FF9C, 32'd7, 5'd9);
        for (int cyc = 1; cyc < 10; cyc++) begin
            start_i = (cyc == 5);
            if (we_o !== 1'b0) seen++;
            @(negedge clk_i);
        end
        start_i = 1'b0;
        chk("kill_busy_before", busy_o, 1'b1);
        kill_i = 1'b1;
        @(negedge clk_i);
        kill_i = 1'b0;
        chk("kill_busy_after", busy_o, 1'b0);
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (we_o !== 1'b0 || busy_o !== 1'b0) seen++;
            @(negedge clk_i);
        end
        chk("kill_no_write", 64'(seen), 64'd0);

        // kill in the DONE cycle suppresses the write
        issue(OP_DIVU, 32'd9, 32'd0, 5'd14);
        kill_i = 1'b1;
        #1;
        chk("kill_done_we", we_o, 1'b0);
        @(negedge clk_i);
        kill_i = 1'b0;
        chk("kill_done_idle", busy_o, 1'b0);

        // kill and start together in IDLE: no accept
        start_i = 1'b1; kill_i = 1'b1; op_i = OP_MUL; a_i = 32'd3; b_i = 32'd4; rd_adr_i = 5'd2;
        @(negedge clk_i);
        start_i = 1'b0; kill_i = 1'b0;
        chk("kill_start_idle", busy_o, 1'b0);
        @(negedge clk_i);
        chk("kill_start_idle2", {busy_o, we_o}, 2'b00);

        // reset in the middle of a multiply
        seen = 0;
        issue(OP_MUL, 32'd123, 32'd456, 5'd3);
        repeat (19) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("midrst_outputs", {busy_o, we_o, wb_adr_o, wb_data_o}, 39'd0);
        chk("midrst_state", dbg_state_o, 2'd0);
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (we_o !== 1'b0) seen++;
            @(negedge clk_i);
        end
        chk("midrst_no_write", 64'(seen), 64'd0);
        run_op("mul_rd0", OP_MUL, 32'd5, 32'd6, 5'd0);

        for (int i = 0; i < 16; i++) begin
            r_op = 3'($urandom_range(0, 7));
            sel  = $urandom_range(0, 3);
            r_a  = (sel == 0) ? $urandom : (sel == 1) ? 32'h8000_0000 :
                   (sel == 2) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 9));
            sel  = $urandom_range(0, 4);
            r_b  = (sel == 0) ? $urandom : (sel == 1) ? 32'd0 :
                   (sel == 2) ? 32'hFFFF_FFFF : (sel == 3) ? 32'h8000_0000 :
                   32'($urandom_range(1, 9));
            run_op("random", r_op, r_a, r_b, 5'($urandom_range(0, 31)));
        end

        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
